// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous initiator for a 1M x 16 asynchronous SRAM.
// Turns single-beat valid/ready requests into CE#/OE#/WE#/LB#/UB# sequences.
// Reads return one response pulse. Writes have a setup cycle, a WE# pulse and
// a hold cycle, so address, lanes and data stay stable across the WE# rising
// edge. Every pin-side signal comes straight from a flop.
module sram_ctrl #(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [19:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  input  logic [1:0]  i_req_be,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_rdata,
  output logic [19:0] o_sram_addr,
  output logic        o_sram_ce_n,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n
);

  // The counter only ever holds "remaining cycles minus one".
  localparam int MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             accept;

  logic [19:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [1:0]  be_reg, be_next;
  logic        ce_n_reg, ce_n_next;
  logic        oe_n_reg, oe_n_next;
  logic        we_n_reg, we_n_next;
  logic        lb_n_reg, lb_n_next;
  logic        ub_n_reg, ub_n_next;
  logic        dq_oe_reg, dq_oe_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [15:0] rsp_rdata_reg, rsp_rdata_next;

  // State register plus every registered pin and response output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      lb_n_reg      <= 1'b1;
      ub_n_reg      <= 1'b1;
      dq_oe_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      be_reg        <= be_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      lb_n_reg      <= lb_n_next;
      ub_n_reg      <= ub_n_next;
      dq_oe_reg     <= dq_oe_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  // Next-state and cycle-counter logic; a request is only taken in IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_req_valid) begin
          accept = 1'b1;
          if (i_req_we) begin
            state_next = S_WR_SETUP;
            cnt_next   = WR_LOAD;
          end else begin
            state_next = S_RD_WAIT;
            cnt_next   = RD_LOAD;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_reg == '0) state_next = S_IDLE;
        else               cnt_next   = cnt_reg - CNT_ONE;
      end
      S_WR_SETUP: state_next = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_reg == '0) state_next = S_WR_HOLD;
        else               cnt_next   = cnt_reg - CNT_ONE;
      end
      S_WR_HOLD: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Pin values for the coming state, so the registered pins line up with it.
  always_comb begin
    addr_next  = accept ? i_req_addr  : addr_reg;
    wdata_next = accept ? i_req_wdata : wdata_reg;
    be_next    = accept ? i_req_be    : be_reg;
    ce_n_next  = 1'b1;
    oe_n_next  = 1'b1;
    we_n_next  = 1'b1;
    lb_n_next  = 1'b1;
    ub_n_next  = 1'b1;
    dq_oe_next = 1'b0;
    case (state_next)
      S_RD_WAIT: begin
        ce_n_next = 1'b0;
        oe_n_next = 1'b0;
        lb_n_next = 1'b0;
        ub_n_next = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_next  = 1'b0;
        lb_n_next  = ~be_next[0];
        ub_n_next  = ~be_next[1];
        dq_oe_next = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_next  = 1'b0;
        we_n_next  = 1'b0;
        lb_n_next  = ~be_next[0];
        ub_n_next  = ~be_next[1];
        dq_oe_next = 1'b1;
      end
      default: ;
    endcase
    // Sample the bus on the last RD_WAIT edge, while OE# is still low.
    rsp_valid_next = (state_reg == S_RD_WAIT) && (cnt_reg == '0);
    rsp_rdata_next = rsp_valid_next ? io_sram_dq : rsp_rdata_reg;
  end

  assign o_req_ready = (state_reg == S_IDLE);
  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_rdata = rsp_rdata_reg;
  assign o_sram_addr = addr_reg;
  assign o_sram_ce_n = ce_n_reg;
  assign o_sram_oe_n = oe_n_reg;
  assign o_sram_we_n = we_n_reg;
  assign o_sram_lb_n = lb_n_reg;
  assign o_sram_ub_n = ub_n_reg;
  assign io_sram_dq  = dq_oe_reg ? wdata_reg : {16{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl. Instance 0 uses RD_CYCLES=2, WR_CYCLES=2. Instance 1
// uses RD_CYCLES=1, WR_CYCLES=3. Each instance drives its own behavioural
// async SRAM, which latches on the WE# rising edge. Reads push their expected
// data and due cycle to a scoreboard, and a monitor pops and compares.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int RD_A = 2;
  localparam int WR_A = 2;
  localparam int RD_B = 1;
  localparam int WR_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_we;
  logic [1:0][19:0] req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0][1:0]  req_be;
  wire  [1:0]       req_ready, rsp_valid, ce_n, lb_n, ub_n, oe_n, we_n, dq_drv;
  wire  [1:0][15:0] rsp_rdata;
  wire  [1:0][19:0] sram_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int RDC = (gi == 0) ? RD_A : RD_B;
    localparam int WRC = (gi == 0) ? WR_A : WR_B;
    wire  [15:0] dq;
    logic [15:0] mem [0:1048575];

    sram_ctrl #(.RD_CYCLES(RDC), .WR_CYCLES(WRC)) u_dut (
      .i_clk       (clk),
      .i_rst       (rst[gi]),
      .i_req_valid (req_valid[gi]),
      .o_req_ready (req_ready[gi]),
      .i_req_we    (req_we[gi]),
      .i_req_addr  (req_addr[gi]),
      .i_req_wdata (req_wdata[gi]),
      .i_req_be    (req_be[gi]),
      .o_rsp_valid (rsp_valid[gi]),
      .o_rsp_rdata (rsp_rdata[gi]),
      .o_sram_addr (sram_addr[gi]),
      .o_sram_ce_n (ce_n[gi]),
      .io_sram_dq  (dq),
      .o_sram_lb_n (lb_n[gi]),
      .o_sram_ub_n (ub_n[gi]),
      .o_sram_oe_n (oe_n[gi]),
      .o_sram_we_n (we_n[gi])
    );

    // Controller's own data-bus drive enable, used only for the bus-contention check.
    assign dq_drv[gi] = u_dut.dq_oe_reg;

    // Async SRAM model: drives on CE#&OE# with WE# high, latches on WE# rise.
    assign dq = (!ce_n[gi] && !oe_n[gi] && we_n[gi]) ? mem[sram_addr[gi]] : 16'hzzzz;
    always @(posedge we_n[gi]) begin
      if (!ce_n[gi]) begin
        if (!lb_n[gi]) mem[sram_addr[gi]][7:0]  <= dq[7:0];
        if (!ub_n[gi]) mem[sram_addr[gi]][15:8] <= dq[15:8];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rd_of(input int k);
    return (k == 0) ? RD_A : RD_B;
  endfunction

  function automatic int wr_of(input int k);
    return (k == 0) ? WR_A : WR_B;
  endfunction

  typedef struct {
    int          inst;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [15:0] ref_mem [int];
  int overlap = 0;
  int we_low [2] = '{0, 0};

  // Monitor: response scoreboard, WE# pulse width and OE#/drive overlap.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc > 2) begin
        for (int k = 0; k < 2; k++) begin
          if (!oe_n[k] && dq_drv[k]) overlap++;
          if (!we_n[k]) we_low[k]++;
          else if (we_low[k] != 0) begin
            chk("we_low_width", we_low[k], wr_of(k));
            we_low[k] = 0;
          end
          if (rsp_valid[k]) begin
            if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
              e = sb.pop_front();
              chk("rsp_inst", k, e.inst);
              chk("rsp_data", rsp_rdata[k], e.data);
              chk("rsp_latency", cyc, e.due);
              chk("rsp_with_ready", req_ready[k], 1);
            end
          end
        end
      end
    end
  end

  // One request: present it, wait for ready, record the accept edge.
  task automatic do_req(input int k, input bit we, input logic [19:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    int waited;
    int acc;
    int key;
    logic [15:0] w;
    exp_t e;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
    req_valid[k] = 1'b1;
    waited = 0;
    while (!req_ready[k] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[k]) begin
      chk("accept_timeout", 0, 1);
      req_valid[k] = 1'b0;
      return;
    end
    acc = cyc + 1;
    key = k * (1 << 20) + int'(a);
    @(posedge clk);
    if (we) begin
      w = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
      if (be[0]) w[7:0]  = d[7:0];
      if (be[1]) w[15:8] = d[15:8];
      if (be != 2'b00 || ref_mem.exists(key)) ref_mem[key] = w;
      $display("txn inst=%0d WR addr=%05h data=%04h be=%b accepted@%0d", k, a, d, be, acc);
    end else begin
      e.inst = k;
      e.data = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
      e.due  = acc + rd_of(k);
      sb.push_back(e);
      $display("txn inst=%0d RD addr=%05h expect=%04h accepted@%0d", k, a, e.data, acc);
    end
    @(negedge clk);
    chk("busy_after_accept", req_ready[k], 0);
    req_valid[k] = 1'b0;
  endtask

  // Called right after a write's do_req: count the cycles ready stays low.
  task automatic check_busy(input int k);
    int n;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("wr_busy_cycles", n, wr_of(k) + 2);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("idle_reached", req_ready[k], 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] addrs [16];
    int acc;
    rst       = 2'b11;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", req_ready[k], 1);
      chk("rst_ce_n", ce_n[k], 1);
      chk("rst_oe_n", oe_n[k], 1);
      chk("rst_we_n", we_n[k], 1);
      chk("rst_lb_n", lb_n[k], 1);
      chk("rst_ub_n", ub_n[k], 1);
      chk("rst_addr", sram_addr[k], 0);
      chk("rst_rsp_valid", rsp_valid[k], 0);
      chk("rst_rsp_rdata", rsp_rdata[k], 0);
      chk("rst_dq_released", dq_drv[k], 0);
    end

    // Full-word write then readback.
    do_req(0, 1'b1, 20'h00010, 16'hBEEF, 2'b11);
    check_busy(0);
    do_req(0, 1'b0, 20'h00010, 16'h0000, 2'b00);
    wait_idle(0);

    // Byte-lane merges, including an all-lanes-off write.
    do_req(0, 1'b1, 20'h00020, 16'h1234, 2'b11);
    do_req(0, 1'b1, 20'h00020, 16'hAB00, 2'b10);
    do_req(0, 1'b0, 20'h00020, 16'h0000, 2'b00);
    do_req(0, 1'b1, 20'h00020, 16'hFFFF, 2'b00);
    check_busy(0);
    do_req(0, 1'b0, 20'h00020, 16'h0000, 2'b00);
    wait_idle(0);

    // Valid held high across alternating requests at the address extremes.
    do_req(0, 1'b1, 20'hFFFFF, 16'h5A5A, 2'b11);
    do_req(0, 1'b0, 20'hFFFFF, 16'h0000, 2'b11);
    do_req(0, 1'b1, 20'h00000, 16'hA5A5, 2'b11);
    do_req(0, 1'b0, 20'h00000, 16'h0000, 2'b11);
    wait_idle(0);

    // Reset during RD_WAIT drops the response.
    req_we[0]    = 1'b0;
    req_addr[0]  = 20'h00010;
    req_valid[0] = 1'b1;
    acc = cyc + 1;
    @(posedge clk);
    $display("txn inst=0 RD addr=00010 (reset during wait) accepted@%0d", acc);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("rd_wait_oe_n", oe_n[0], 0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("rstmid_ce_n", ce_n[0], 1);
    chk("rstmid_oe_n", oe_n[0], 1);
    chk("rstmid_dq_released", dq_drv[0], 0);
    chk("rstmid_ready", req_ready[0], 1);
    chk("rstmid_rsp_valid", rsp_valid[0], 0);
    repeat (4) @(negedge clk);
    do_req(0, 1'b0, 20'h00010, 16'h0000, 2'b00);
    do_req(0, 1'b0, 20'hFFFFF, 16'h0000, 2'b00);
    wait_idle(0);

    // Second build: read latency 1, write busy 5 cycles.
    do_req(1, 1'b1, 20'h00100, 16'h1357, 2'b11);
    check_busy(1);
    do_req(1, 1'b0, 20'h00100, 16'h0000, 2'b00);
    wait_idle(1);

    // Random lane writes over a small address set, then read everything back.
    for (int i = 0; i < 16; i++) begin
      addrs[i] = 20'($urandom_range(0, 20'hFFFFF));
      do_req(1, 1'b1, addrs[i], 16'($urandom), 2'b11);
    end
    for (int i = 0; i < 64; i++) begin
      do_req(1, 1'b1, addrs[$urandom_range(0, 15)], 16'($urandom), 2'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      do_req(1, 1'b0, addrs[i], 16'h0000, 2'b00);
    end
    wait_idle(1);

    repeat (4) @(negedge clk);
    chk("oe_dq_overlap", overlap, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
